// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default datapath width and the
// requester-ID type used by the ALU issue arbiter.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 6;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef logic req_id_t;

    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_e;

endpackage

// File: rtl/alu_control.sv
// Maps a 6-bit instruction field onto the 4-bit ALU opcode; the first
// matching rule wins.
module alu_control
    import alu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic [3:0]         alu_op_o
);

    always_comb begin
        alu_op_o = ALU_AND;
        if (instr_i[5:4] == 2'b00) begin
            alu_op_o = ALU_ADD;
        end else if (instr_i[5:4] == 2'b01 || (instr_i[5] && instr_i[3:0] == 4'b0000)) begin
            alu_op_o = ALU_SUB;
        end else if (instr_i[5:4] == 2'b10) begin
            alu_op_o = ALU_ADD;
        end else begin
            alu_op_o = ALU_AND;
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Two-requester issue arbiter for the shared single-cycle ALU with a
// registered, ID-tagged result. Define ALU_ISSUE_FIXED_PRIO_EN for fixed priority.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
    input  logic [NUM_REQ*XLEN-1:0]    req_a,
    input  logic [NUM_REQ*XLEN-1:0]    req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [XLEN-1:0]            res_data,
    output logic                       res_zero,
    output logic                       res_id
);

    // Handshake: a transfer happens on valid & ready in the same cycle; ready is
    // never raised without valid, and a requester holds its payload until transfer.

    res_state_e           state_q, state_d;
    logic [XLEN-1:0]      res_data_q;
    logic                 res_zero_q;
    req_id_t              res_id_q;

    logic                 can_accept;
    logic                 grant_any;
    req_id_t              grant_id;
    logic                 xfer;
    logic [INSTR_W-1:0]   sel_instr;
    logic [XLEN-1:0]      sel_a;
    logic [XLEN-1:0]      sel_b;
    logic [3:0]           alu_op;
    logic [XLEN-1:0]      alu_result;

    function automatic logic [XLEN-1:0] alu_exec(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (op)
            ALU_ADD: alu_exec = a + b;
            ALU_SUB: alu_exec = a - b;
            ALU_AND: alu_exec = a & b;
            ALU_OR:  alu_exec = a | b;
            default: alu_exec = '0;
        endcase
    endfunction

    assign can_accept = (state_q == RES_EMPTY) || res_ready;
    assign grant_any  = |req_valid;

`ifdef ALU_ISSUE_FIXED_PRIO_EN
    assign grant_id = req_valid[0] ? 1'b0 : 1'b1;
`else
    req_id_t rr_ptr_q;

    // Contention goes to rr_ptr; a lone requester always wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_id = rr_ptr_q;
        end else begin
            grant_id = req_valid[0] ? 1'b0 : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
        end else if (xfer) begin
            rr_ptr_q <= ~grant_id;
        end
    end
`endif

    assign xfer         = !reset && can_accept && grant_any;
    assign req_ready[0] = xfer && (grant_id == 1'b0);
    assign req_ready[1] = xfer && (grant_id == 1'b1);

    assign sel_instr = grant_id ? req_instr[2*INSTR_W-1:INSTR_W] : req_instr[INSTR_W-1:0];
    assign sel_a     = grant_id ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
    assign sel_b     = grant_id ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];

    alu_control u_alu_control (
        .instr_i  (sel_instr),
        .alu_op_o (alu_op)
    );

    assign alu_result = alu_exec(alu_op, sel_a, sel_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RES_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RES_EMPTY: state_d = xfer ? RES_FULL : RES_EMPTY;
            RES_FULL: begin
                if (xfer) begin
                    state_d = RES_FULL;
                end else if (res_ready) begin
                    state_d = RES_EMPTY;
                end else begin
                    state_d = RES_FULL;
                end
            end
            default: state_d = RES_EMPTY;
        endcase
    end

    always_comb begin
        res_valid = (state_q == RES_FULL);
        res_data  = res_data_q;
        res_zero  = res_zero_q;
        res_id    = res_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_id_q   <= 1'b0;
        end else if (xfer) begin
            res_data_q <= alu_result;
            res_zero_q <= (alu_result == '0);
            res_id_q   <= grant_id;
        end
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single-cycle integer ALU between two requesters: port 0 is the execute stage, port 1 is the branch/address unit.
- Performs round-robin arbitration with valid/ready handshakes on every request and result port.
- Derives the 4-bit ALU opcode from each request's 6-bit instruction field, using the team's existing opcode mapping.
- Executes the operation and holds a registered result, tagged with the requester ID, until the consumer accepts it.

Parameters:
- XLEN, 32, operand and result width.
- NUM_REQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid.
- req_ready  output  2  per-requester grant; bit i high means requester i's request is accepted this cycle.
- req_instr  input  2x6  per-requester instruction bits, used for opcode derivation.
- req_a  input  2xXLEN  per-requester operand A.
- req_b  input  2xXLEN  per-requester operand B.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  XLEN  ALU result.
- res_zero  output  1  high when res_data == 0.
- res_id  output  1  requester ID that owns res_data.

Behaviour:
- Reset: res_valid=0, res_data=0, res_zero=0, res_id=0, rr_ptr=0 (requester 0 favoured first). req_ready is combinational and 0 while reset is high.
- Result register states: EMPTY (res_valid=0) or FULL (res_valid=1).
- can_accept = EMPTY | (FULL & res_ready).
- Grant, combinational:
  - If can_accept=0, no grant.
  - If exactly one req_valid is set, that requester is granted.
  - If both are set, the grant goes to rr_ptr.
  - req_ready[i] = can_accept & grant==i. At most one bit of req_ready is ever high.
- Handshake:
  - A transfer occurs on req_valid[i] & req_ready[i].
  - A requester holds req_valid, req_instr, req_a and req_b stable until its transfer.
  - req_ready is only asserted when req_valid is high (no ready without valid).
- Latency:
  - Request transferred in cycle T appears at T+1 with res_valid=1, res_id=i, and res_data=ALU(op, req_a[i], req_b[i]).
  - res_zero = (res_data == 0).
- Throughput: one op per cycle while res_ready is held high.
- Backpressure: while FULL & !res_ready, res_data, res_zero and res_id are held and no grant is issued.
- Simultaneous events: when FULL & res_ready and a transfer happen in the same cycle, the register reloads with the new result and res_valid stays 1.
- Drain: when FULL & res_ready with no transfer, the register goes EMPTY next cycle.
- rr_ptr update: after any transfer, rr_ptr = ~granted_id. rr_ptr is unchanged when no transfer occurs.
- Opcode derivation, from instr[5:0], first match wins:
  - [5:4]==00 -> ADD (0010)
  - [5:4]==01, or ([5]==1 & [3:0]==0000) -> SUB (0110)
  - [5:4]==10 -> ADD (0010)
  - otherwise -> AND (0000)
- ALU operations:
  - 0010: A+B, wraps modulo 2^XLEN, carry discarded.
  - 0110: A-B, two's complement, wraps modulo 2^XLEN.
  - 0000: A&B.
  - 0001: A|B.
  - Any other opcode: result 0.
- Reset mid-operation: a pending result is discarded and res_valid=0 the next cycle. Requesters re-present their requests after reset.

Optional Feature:
- Macro: ALU_ISSUE_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention; rr_ptr is not implemented. Requester 1 is granted only when req_valid[0]=0.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110;
  - XLEN default;
  - a typedef for the 1-bit requester ID.
- Sub-module: the existing alu_control block, instantiated on the granted requester's req_instr (selected through a mux) to produce the opcode.
- The ALU datapath is a local combinational function.
- Arbitration stays inline: it is too small to warrant its own module.

Test Plan:
1. Reset held 3 cycles with both req_valid=1 -> req_ready=00, res_valid=0, res_data=0. After release, requester 0 is granted first.
2. Requester 0 alone, instr=6'b000000, A=5, B=7, res_ready=1 -> req_ready=01 at T; at T+1 res_valid=1, res_data=12, res_id=0, res_zero=0.
3. Both valid continuously with res_ready=1:
   - requester 0: instr=6'b010000, A=9, B=9;
   - requester 1: instr=6'b100101, A=3, B=4;
   - grants alternate 0,1,0,1;
   - id 0 results: 0 with res_zero=1; id 1 results: 7.
4. Backpressure: result FULL with res_ready=0 for 4 cycles -> req_ready=00, outputs stable. When res_ready=1 returns, a new transfer occurs the same cycle and res_valid stays high.
5. Wrap-around: A=32'hFFFFFFFF, B=1, ADD -> res_data=0, res_zero=1. A=0, B=1, SUB (instr=6'b100000) -> res_data=32'hFFFFFFFF.
6. With ALU_ISSUE_FIXED_PRIO_EN defined and both requesters valid for 5 cycles -> req_ready=01 every cycle and requester 1 is never granted. Reset asserted while FULL -> res_valid=0 the next cycle.
